// File: rtl/npu_pkg.sv
// Shared definitions for the mean-reduction job issuer: FSM encoding,
// packed params field positions and the default unit timeout.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_WRITE     = 2'd3
  } issuer_state_e;

  localparam int DIMS_MSB = 31;
  localparam int DIMS_LSB = 16;
  localparam int AXES_MSB = 15;
  localparam int AXES_LSB = 0;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef struct packed {
    logic [31:0] ptr;
    logic [31:0] params;
    logic [31:0] dst;
  } job_t;

endpackage

// File: rtl/job_fifo.sv
// Synchronous circular FIFO; full/empty are derived from the occupancy count
// so a simultaneous push and pop is legal even when full.
module job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mean_job_issuer.sv
// Queues reduction jobs and issues them one at a time to a mean unit,
// turning each done pulse (or a timeout) into a single write-back beat.
module mean_job_issuer
  import npu_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_ptr,
  input  logic [31:0]        cmd_params,
  input  logic [31:0]        cmd_dst,
  output logic               unit_start,
  output logic [31:0]        unit_input_ptr,
  output logic [31:0]        unit_params,
  input  logic               unit_ready,
  input  logic               unit_done,
  input  logic [31:0]        unit_result,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [31:0]        wb_addr,
  output logic [31:0]        wb_data,
  output logic               wb_err,
  output logic               busy,
  output logic [CNT_W-1:0]   jobs_done,
  output logic               timeout_flag,
  output issuer_state_e      dbg_state
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshakes: cmd and wb transfer on the cycle where valid and ready are both
  // high; a valid side holds its payload stable until that cycle. unit_start is
  // only raised while unit_ready is high and lasts exactly one cycle.

  issuer_state_e       state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  job_t                job_q, job_d;
  logic [31:0]         wb_addr_q, wb_addr_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                wb_err_q, wb_err_d;
  logic [CNT_W-1:0]    jobs_done_q, jobs_done_d;
  logic                timeout_flag_q, timeout_flag_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$bits(job_t)-1:0]     fifo_rdata;
  logic [$clog2(CMD_DEPTH):0]  fifo_count;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  job_fifo #(
    .WIDTH ($bits(job_t)),
    .DEPTH (CMD_DEPTH)
  ) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({cmd_ptr, cmd_params, cmd_dst}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    job_d          = job_q;
    wb_addr_d      = wb_addr_q;
    wb_data_d      = wb_data_q;
    wb_err_d       = wb_err_q;
    jobs_done_d    = jobs_done_q;
    timeout_flag_d = timeout_flag_q;
    fifo_pop       = 1'b0;
    unit_start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          job_d    = job_t'(fifo_rdata);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (unit_ready) begin
          unit_start = 1'b1;
          timer_d    = '0;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A done pulse in the expiry cycle still counts as a real result.
        if (unit_done) begin
          wb_addr_d = job_q.dst;
          wb_data_d = unit_result;
          wb_err_d  = 1'b0;
          state_d   = ST_WRITE;
        end else if (timer_q == TIMER_LAST) begin
          wb_addr_d      = job_q.dst;
          wb_data_d      = '0;
          wb_err_d       = 1'b1;
          timeout_flag_d = 1'b1;
          state_d        = ST_WRITE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WRITE: begin
        if (wb_ready) begin
          jobs_done_d = jobs_done_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      job_q          <= '0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      wb_err_q       <= 1'b0;
      jobs_done_q    <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      job_q          <= job_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      wb_err_q       <= wb_err_d;
      jobs_done_q    <= jobs_done_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign unit_input_ptr = job_q.ptr;
  assign unit_params    = {job_q.params[DIMS_MSB:DIMS_LSB], job_q.params[AXES_MSB:AXES_LSB]};
  assign wb_valid       = (state_q == ST_WRITE);
  assign wb_addr        = wb_addr_q;
  assign wb_data        = wb_data_q;
  assign wb_err         = wb_err_q;
  assign busy           = (fifo_count != '0) || (state_q != ST_IDLE);
  assign jobs_done      = jobs_done_q;
  assign timeout_flag   = timeout_flag_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mean_job_issuer.sv
// Bench for mean_job_issuer: a behavioural mean-unit responder, an in-order
// write-back scoreboard, a table-driven queue-full test and directed corners.
module tb_mean_job_issuer;
  import npu_pkg::*;

  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_ptr = '0, cmd_params = '0, cmd_dst = '0;
  logic        host_ready = 1'b1, resp_ready = 1'b1, rnd_ur = 1'b1;
  logic        unit_ready;
  logic        resp_done = 1'b0, man_done = 1'b0;
  logic [31:0] resp_result = '0, man_result = '0;
  logic        unit_done;
  logic [31:0] unit_result;
  logic        wb_ready_drv = 1'b1, rnd_wb = 1'b1, wb_ready;

  assign unit_ready  = host_ready & resp_ready & rnd_ur;
  assign unit_done   = resp_done | man_done;
  assign unit_result = man_done ? man_result : resp_result;
  assign wb_ready    = wb_ready_drv & rnd_wb;

  // ---------------- DUT outputs ----------------
  logic cmd_ready, unit_start, wb_valid, wb_err, busy, timeout_flag;
  logic [31:0] unit_input_ptr, unit_params, wb_addr, wb_data;
  logic [CNT_W-1:0] jobs_done;
  issuer_state_e dbg_state;

  logic to_cmd_ready, to_unit_start, to_wb_valid, to_wb_err, to_busy, to_timeout_flag;
  logic [31:0] to_unit_input_ptr, to_unit_params, to_wb_addr, to_wb_data;
  logic [CNT_W-1:0] to_jobs_done;
  issuer_state_e to_dbg_state;

  mean_job_issuer #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(1024), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ptr(cmd_ptr), .cmd_params(cmd_params), .cmd_dst(cmd_dst),
    .unit_start(unit_start), .unit_input_ptr(unit_input_ptr), .unit_params(unit_params),
    .unit_ready(unit_ready), .unit_done(unit_done), .unit_result(unit_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_err(wb_err), .busy(busy), .jobs_done(jobs_done), .timeout_flag(timeout_flag),
    .dbg_state(dbg_state)
  );

  mean_job_issuer #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(16), .CNT_W(CNT_W)) dut_to (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(to_cmd_ready),
    .cmd_ptr(cmd_ptr), .cmd_params(cmd_params), .cmd_dst(cmd_dst),
    .unit_start(to_unit_start), .unit_input_ptr(to_unit_input_ptr), .unit_params(to_unit_params),
    .unit_ready(unit_ready), .unit_done(unit_done), .unit_result(unit_result),
    .wb_valid(to_wb_valid), .wb_ready(wb_ready), .wb_addr(to_wb_addr), .wb_data(to_wb_data),
    .wb_err(to_wb_err), .busy(to_busy), .jobs_done(to_jobs_done), .timeout_flag(to_timeout_flag),
    .dbg_state(to_dbg_state)
  );

  // ---------------- check plumbing ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- mean-unit model ----------------
  bit          resp_en = 1'b1;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_val = '0;
  int          lat_min = 3, lat_max = 3;
  int          r_lat;
  logic [31:0] r_p, r_q;

  function automatic logic [31:0] exp_res(input logic [31:0] p, input logic [31:0] q);
    return fixed_en ? fixed_val : ((p ^ {q[15:0], q[31:16]}) + 32'h1);
  endfunction

  // Drops ready two cycles after start and pulses done r_lat cycles after start.
  initial forever begin
    @(negedge clk);
    if (resp_en && unit_start && !rst) begin
      r_lat = $urandom_range(lat_max, lat_min);
      r_p = unit_input_ptr;
      r_q = unit_params;
      for (int i = 1; i <= r_lat; i++) begin
        @(posedge clk); #1;
        if (i == 2) resp_ready = 1'b0;
      end
      resp_result = exp_res(r_p, r_q);
      resp_done = 1'b1;
      @(posedge clk); #1;
      resp_done = 1'b0;
      resp_ready = 1'b1;
    end
  end

  bit rnd_en = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    rnd_wb = rnd_en ? ($urandom_range(3, 0) != 0) : 1'b1;
    rnd_ur = rnd_en ? ($urandom_range(3, 0) != 0) : 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [64:0]      exp_q[$];
  logic [64:0]      prev_beat = '0;
  logic             prev_hold = 1'b0, prev_start = 1'b0;
  logic [CNT_W-1:0] model_done = '0;
  logic [31:0]      last_params = '0;
  int               beats = 0, starts = 0;
  bit               sb_en = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_done = '0;
      prev_hold  = 1'b0;
      prev_start = 1'b0;
    end else if (sb_en) begin
      if (prev_hold) check("wb_hold_stable", {wb_valid, wb_err, wb_addr, wb_data}, {1'b1, prev_beat});
      if (wb_valid && wb_ready) begin
        check("wb_expected_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("wb_beat", {wb_err, wb_addr, wb_data}, exp_q.pop_front());
        beats++;
        model_done = model_done + 1'b1;
      end
      prev_hold = wb_valid && !wb_ready;
      prev_beat = {wb_err, wb_addr, wb_data};
      if (unit_start) begin
        starts++;
        last_params = unit_params;
        check("start_not_back_to_back", prev_start, 1'b0);
        check("start_with_ready", unit_ready, 1'b1);
      end
      prev_start = unit_start;
    end else begin
      prev_hold  = 1'b0;
      prev_start = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_job(input logic [31:0] p, input logic [31:0] q, input logic [31:0] d);
    int g = 0;
    cmd_ptr = p; cmd_params = q; cmd_dst = d; cmd_valid = 1'b1;
    while (!cmd_ready && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    check("push_accepted_in_budget", g < 3000, 1'b1);
    exp_q.push_back({1'b0, d, exp_res(p, q)});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while ((exp_q.size() != 0 || busy || wb_valid) && g < budget) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_in_budget", g < budget, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_unit_side"}, {unit_start, unit_input_ptr, unit_params}, '0);
    check({tag, "_wb_side"}, {wb_valid, wb_err, wb_addr, wb_data}, '0);
    check({tag, "_status"}, {busy, timeout_flag, jobs_done}, '0);
  endtask

  typedef struct {
    logic [31:0] ptr;
    logic [31:0] params;
    logic [31:0] dst;
    logic        exp_ready;
  } qf_vec_t;

  qf_vec_t qf_tab[5];

  // ---------------- test sequence ----------------
  initial begin
    int s0, b0, g;
    logic [CNT_W-1:0] base;
    logic seen;

    qf_tab[0] = '{32'h0000_A000, 32'h0003_0001, 32'h0000_B000, 1'b1};
    qf_tab[1] = '{32'h0000_A100, 32'h0003_0002, 32'h0000_B100, 1'b1};
    qf_tab[2] = '{32'h0000_A200, 32'h0004_0001, 32'h0000_B200, 1'b1};
    qf_tab[3] = '{32'h0000_A300, 32'h0004_0002, 32'h0000_B300, 1'b1};
    qf_tab[4] = '{32'h0000_A400, 32'h0005_0003, 32'h0000_B400, 1'b0};

    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Single job with a slow unit.
    cycles(2);
    fixed_en = 1'b1; fixed_val = 32'h1; lat_min = 260; lat_max = 260;
    s0 = starts;
    push_job(32'h1000, 32'h0002_0001, 32'h2000);
    drain(400);
    check("single_start_count", starts - s0, 1);
    check("single_start_params", last_params, 32'h0002_0001);
    check("single_jobs_done", jobs_done, 16'd1);

    // Unit busy: job waits in ISSUE untimed.
    fixed_en = 1'b0; lat_min = 4; lat_max = 4;
    host_ready = 1'b0;
    s0 = starts;
    push_job(32'h7000, 32'h0001_0002, 32'h7100);
    cycles(50);
    check("ubusy_no_start", starts - s0, 0);
    check("ubusy_state", dbg_state, ST_ISSUE);
    check("ubusy_no_timeout", {timeout_flag, wb_valid}, 2'b00);
    host_ready = 1'b1;
    @(negedge clk);
    check("ubusy_start_on_ready", unit_start, 1'b1);
    cycles(1);
    drain(200);

    // Queue full, table driven, with the write-back stalled.
    lat_min = 3; lat_max = 3;
    wb_ready_drv = 1'b0;
    b0 = beats;
    for (int i = 0; i < 5; i++) begin
      push_job(qf_tab[i].ptr, qf_tab[i].params, qf_tab[i].dst);
      check($sformatf("qfull_cmd_ready_%0d", i), cmd_ready, qf_tab[i].exp_ready);
    end
    cycles(6);
    check("qfull_ready_held_low", {cmd_ready, wb_valid}, 2'b01);
    wb_ready_drv = 1'b1;
    drain(500);
    check("qfull_beats", beats - b0, 5);
    check("qfull_jobs_done", jobs_done, model_done);

    // Backpressure on the write-back beat.
    fixed_en = 1'b1; fixed_val = 32'hDEAD_BEEF; lat_min = 5; lat_max = 5;
    wb_ready_drv = 1'b0;
    push_job(32'h3000, 32'h0004_0003, 32'h4000);
    g = 0;
    while (!wb_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("bp_valid_in_budget", g < 100, 1'b1);
    base = jobs_done;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_beat_stable", {wb_valid, wb_err, wb_addr, wb_data}, {1'b1, 1'b0, 32'h4000, 32'hDEAD_BEEF});
      check("bp_count_held", jobs_done, base);
    end
    @(posedge clk); #1;
    wb_ready_drv = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_count_after_accept", jobs_done, base + 1'b1);
    check("bp_valid_dropped", wb_valid, 1'b0);

    // Randomized traffic against the scoreboard.
    cycles(1);
    fixed_en = 1'b0; lat_min = 3; lat_max = 30;
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycles($urandom_range(6, 0));
      push_job($urandom, $urandom, $urandom);
    end
    drain(20000);
    rnd_en = 1'b0;
    cycles(2);
    check("rand_jobs_done", jobs_done, model_done);
    check("rand_no_timeout", timeout_flag, 1'b0);

    // Reset while a job is in flight and two are queued.
    lat_min = 200; lat_max = 200;
    push_job(32'h8000, 32'h0001_0001, 32'h8100);
    push_job(32'h8200, 32'h0001_0001, 32'h8300);
    push_job(32'h8400, 32'h0001_0001, 32'h8500);
    cycles(5);
    check("midrst_pre_state", {dbg_state, busy}, {ST_WAIT_DONE, 1'b1});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    b0 = beats;
    cycles(260);
    check("midrst_no_wb", beats - b0, 0);
    check("midrst_idle", {busy, jobs_done}, '0);

    // Timeout on the short-timeout instance; a late done is ignored.
    sb_en = 1'b0; resp_en = 1'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    push_job(32'h5000, 32'h0001_0001, 32'h6000);
    g = 0;
    @(negedge clk);
    while (!to_unit_start && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("to_start_seen", to_unit_start, 1'b1);
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      seen = seen | to_wb_valid;
    end
    check("to_no_early_beat", seen, 1'b0);
    @(negedge clk);
    check("to_beat", {to_wb_valid, to_wb_err, to_wb_data, to_wb_addr}, {1'b1, 1'b1, 32'h0, 32'h6000});
    check("to_flag", to_timeout_flag, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    man_result = 32'h0000_ABCD; man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen = seen | to_wb_valid;
    end
    check("to_late_done_ignored", seen, 1'b0);
    check("to_jobs_done", {to_busy, to_jobs_done, to_timeout_flag}, {1'b0, 16'd1, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
